// File: rtl/vga_pkg.sv
// Shared display geometry and the game-state encoding used by the
// sequencer, both pad controllers and the ball logic.
package vga_pkg;

    // Visible raster
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    // Pad geometry and placement
    localparam int PAD_WIDTH  = 16;
    localparam int PAD_HEIGHT = 96;
    localparam int PAD_OFFSET = 32;
    localparam int PAD_STEP   = 4;

    // Game state bus; pads and ball sit at home position outside PLAY
    typedef enum logic [1:0] {
        START   = 2'b00,
        PLAY    = 2'b01,
        POINT   = 2'b10,
        ENDGAME = 2'b11
    } game_state_t;

endpackage : vga_pkg

// File: rtl/game_tick_gen.sv
// Free-running movement tick: one-cycle pulse every TICK_DIV clocks.
// The pulse is registered, so it appears in the cycle after the divider
// reaches its last count.
module game_tick_gen #(
    parameter int TICK_DIV = 650_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic timing_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap      = (r_div_cnt == DIV_LAST);
    assign timing_tick = r_tick;

    // Divider counts up and wraps; the tick flop marks the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= w_wrap;
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + CW'(1);
        end
    end

endmodule : game_tick_gen

// File: rtl/game_state_ctrl.sv
// Pong game sequencer: owns the game state bus, the per-player scores,
// serve direction and winner, and the hold time between points.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  START   | waiting for start press, scores cleared
//  PLAY    | rally in progress, miss pulses score a point
//  POINT   | pause of POINT_HOLD ticks before the next serve
//  ENDGAME | a player reached WIN_SCORE, waiting for start press
module game_state_ctrl
    import vga_pkg::*;
#(
    parameter int TICK_DIV   = 650_000,
    parameter int WIN_SCORE  = 9,
    parameter int POINT_HOLD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [1:0] state,
    output logic       timing_tick,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       serve_dir,
    output logic       winner
);

    localparam int HOLD_W = $clog2(POINT_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    game_state_t       r_state;
    game_state_t       w_state_nxt;
    logic [3:0]        r_score_l;
    logic [3:0]        r_score_r;
    logic [3:0]        w_score_l_nxt;
    logic [3:0]        w_score_r_nxt;
    logic [3:0]        w_score_l_inc;
    logic [3:0]        w_score_r_inc;
    logic              r_serve_dir;
    logic              w_serve_dir_nxt;
    logic              r_winner;
    logic              w_winner_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_start_s1;
    logic              r_start_s2;
    logic              r_start_s2_d;
    logic              w_start_rise;
    logic              w_tick;
    logic              r_miss_l_d;
    logic              r_miss_r_d;

    game_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .timing_tick (w_tick)
    );

    assign w_start_rise  = r_start_s2 & ~r_start_s2_d;
    assign w_score_l_inc = r_score_l + 4'd1;
    assign w_score_r_inc = r_score_r + 4'd1;

    assign state       = r_state;
    assign timing_tick = w_tick;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign serve_dir   = r_serve_dir;
    assign winner      = r_winner;

    // Two-flop synchronizer on the raw button plus a delay flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_s1   <= 1'b0;
            r_start_s2   <= 1'b0;
            r_start_s2_d <= 1'b0;
        end else begin
            r_start_s1   <= start_in;
            r_start_s2   <= r_start_s1;
            r_start_s2_d <= r_start_s2;
        end
    end

    // State, scores, serve direction and winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= START;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_serve_dir <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    // Hold counter only runs in POINT, so it is already zero on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (r_state != POINT) begin
            r_hold_cnt <= '0;
        end else if (w_tick) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // Next-state and score decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;
        case (r_state)
            START: begin
                if (w_start_rise) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (miss_l && !miss_r) begin
                    w_score_r_nxt   = w_score_r_inc;
                    w_serve_dir_nxt = 1'b0;
                    if (w_score_r_inc == WIN) begin
                        w_state_nxt  = ENDGAME;
                        w_winner_nxt = 1'b1;
                    end else begin
                        w_state_nxt = POINT;
                    end
                end else if (miss_r && !miss_l) begin
                    w_score_l_nxt   = w_score_l_inc;
                    w_serve_dir_nxt = 1'b1;
                    if (w_score_l_inc == WIN) begin
                        w_state_nxt  = ENDGAME;
                        w_winner_nxt = 1'b0;
                    end else begin
                        w_state_nxt = POINT;
                    end
                end else if (miss_l && miss_r) begin
                    // Simultaneous misses are a replay: nobody scores
                    w_state_nxt = POINT;
                end
            end
            POINT: begin
                if (w_tick && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt = PLAY;
                end
            end
            ENDGAME: begin
                if (w_start_rise) begin
                    w_state_nxt     = START;
                    w_score_l_nxt   = 4'd0;
                    w_score_r_nxt   = 4'd0;
                    w_serve_dir_nxt = 1'b0;
                    w_winner_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    // Previous-cycle miss levels, only consumed by the pulse-width checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_l_d <= 1'b0;
            r_miss_r_d <= 1'b0;
        end else begin
            r_miss_l_d <= miss_l;
            r_miss_r_d <= miss_r;
        end
    end

    // Simulation checks on parameter ranges and miss pulse width
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (WIN_SCORE >= 1 && WIN_SCORE <= 15)
                else $error("WIN_SCORE out of range 1..15");
            assert (TICK_DIV >= 2)
                else $error("TICK_DIV must be at least 2");
            assert (POINT_HOLD >= 1)
                else $error("POINT_HOLD must be at least 1");
            assert (!(miss_l && r_miss_l_d))
                else $warning("miss_l held longer than one cycle");
            assert (!(miss_r && r_miss_r_d))
                else $warning("miss_r held longer than one cycle");
        end
    end

endmodule : game_state_ctrl
